// File: rtl/mul_sched.sv
// mul_sched: round-robin front end and sign-correcting controller for the shared iterative 32x32 multiplier.
// Optional build macro MUL_SCHED_ZERO_BYPASS_EN: ops with a zero operand skip the multiplier.
module mul_sched #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    input  logic [NUM_REQ*2-1:0]     req_op,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic                     flush,
    output logic                     mul_valid_in,
    input  logic                     mul_ready,
    output logic [31:0]              mul_multiplier,
    output logic [31:0]              mul_multiplicand,
    input  logic                     mul_valid_out,
    input  logic [63:0]              mul_product,
    output logic                     mul_yumi,
    output logic                     cdb_valid,
    input  logic                     cdb_ready,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [31:0]              cdb_data
);

    localparam int unsigned N     = NUM_REQ;
    localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [31:0]        r_mag_a;
    logic [31:0]        r_mag_b;
    logic [31:0]        r_cdb_data;
    logic [TAG_W-1:0]   r_tag;
    logic [1:0]         r_op;
    logic               r_neg;

    int unsigned        w_idx;
    int unsigned        w_gidx;
    logic               w_found;
    logic [NUM_REQ-1:0] w_grant;
    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic [1:0]         w_op;
    logic [TAG_W-1:0]   w_tag;
    logic               w_a_s;
    logic               w_b_s;
    logic [31:0]        w_mag_a;
    logic [31:0]        w_mag_b;
    logic               w_neg;
    logic [63:0]        w_res64;
    logic               w_hs;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_idx   = 0;
        w_gidx  = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (32'(r_ptr) + k) % N;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
        w_grant[w_gidx] = w_found;
    end

    assign w_a     = req_a[w_gidx*32 +: 32];
    assign w_b     = req_b[w_gidx*32 +: 32];
    assign w_op    = req_op[w_gidx*2 +: 2];
    assign w_tag   = req_tag[w_gidx*TAG_W +: TAG_W];
    assign w_a_s   = (w_op == 2'b01) || (w_op == 2'b10);
    assign w_b_s   = (w_op == 2'b01);
    assign w_mag_a = (w_a_s && w_a[31]) ? (~w_a + 32'd1) : w_a;
    assign w_mag_b = (w_b_s && w_b[31]) ? (~w_b + 32'd1) : w_b;
    assign w_neg   = (w_a_s & w_a[31]) ^ (w_b_s & w_b[31]);
    assign w_res64 = r_neg ? (~mul_product + 64'd1) : mul_product;
    assign w_hs    = (r_state == S_IDLE) && w_found && !flush;

    assign req_ready        = ((r_state == S_IDLE) && !reset && !flush) ? w_grant : '0;
    assign mul_valid_in     = (r_state == S_LAUNCH);
    assign mul_yumi         = mul_valid_out && ((r_state == S_WAIT) || (r_state == S_DRAIN));
    assign cdb_valid        = (r_state == S_RESP);
    assign cdb_tag          = r_tag;
    assign cdb_data         = r_cdb_data;
    assign mul_multiplicand = r_mag_a;
    assign mul_multiplier   = r_mag_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_cdb_data <= '0;
            r_tag      <= '0;
            r_op       <= '0;
            r_neg      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_tag   <= w_tag;
                        r_op    <= w_op;
                        r_neg   <= w_neg;
                        r_ptr   <= PTR_W'((w_gidx + 1) % N);
`ifdef MUL_SCHED_ZERO_BYPASS_EN
                        if ((w_mag_a == '0) || (w_mag_b == '0)) begin
                            r_cdb_data <= '0;
                            r_state    <= S_RESP;
                        end else begin
                            r_state <= S_LAUNCH;
                        end
`else
                        r_state <= S_LAUNCH;
`endif
                    end
                end
                S_LAUNCH: begin
                    if (flush)
                        r_state <= S_IDLE;
                    else if (mul_ready)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A product arriving with flush is still consumed by the yumi pulse, so no drain is needed.
                    if (mul_valid_out) begin
                        if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cdb_data <= (r_op == 2'b00) ? w_res64[31:0] : w_res64[63:32];
                            r_state    <= S_RESP;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_RESP: begin
                    if (flush || cdb_ready)
                        r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (mul_valid_out)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: behavioural 65-cycle multiplier, scoreboard of expected CDB results.
// Honours MUL_SCHED_ZERO_BYPASS_EN for the zero-operand latency expectation.
module tb_mul_sched;

    localparam int NR = 2;
    localparam int TW = 6;
`ifdef MUL_SCHED_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [1:0] OP_MUL = 2'b00, OP_MULH = 2'b01, OP_MULHSU = 2'b10, OP_MULHU = 2'b11;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*32-1:0]  req_a;
    logic [NR*32-1:0]  req_b;
    logic [NR*2-1:0]   req_op;
    logic [NR*TW-1:0]  req_tag;
    logic              flush;
    logic              mul_valid_in;
    logic              mul_ready;
    logic [31:0]       mul_multiplier;
    logic [31:0]       mul_multiplicand;
    logic              mul_valid_out;
    logic [63:0]       mul_product;
    logic              mul_yumi;
    logic              cdb_valid;
    logic              cdb_ready;
    logic [TW-1:0]     cdb_tag;
    logic [31:0]       cdb_data;

    always #5 clk = ~clk;

    mul_sched #(.NUM_REQ(NR), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .flush(flush),
        .mul_valid_in(mul_valid_in), .mul_ready(mul_ready),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_valid_out(mul_valid_out), .mul_product(mul_product), .mul_yumi(mul_yumi),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    // Iterative multiplier: product valid 65 cycles after the load handshake, held until yumi.
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_x, m_y;
    assign mul_ready = !m_busy;
    always @(posedge clk) begin
        if (reset) begin
            m_busy        <= 1'b0;
            m_cnt         <= 0;
            mul_valid_out <= 1'b0;
            mul_product   <= '0;
        end else if (!m_busy) begin
            if (mul_valid_in) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_x    <= mul_multiplicand;
                m_y    <= mul_multiplier;
            end
        end else if (!mul_valid_out) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 63) begin
                mul_valid_out <= 1'b1;
                mul_product   <= {32'b0, m_x} * {32'b0, m_y};
            end
        end else if (mul_yumi) begin
            mul_valid_out <= 1'b0;
            m_busy        <= 1'b0;
        end
    end

    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   data;
        int            acc;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    int            grants[$];
    exp_t          e_new, e_got;
    int            n_checks = 0, n_fail = 0;
    int            cyc = 0, n_done = 0, n_rise = 0, yumi_cnt = 0, mvi_cnt = 0;
    int            last_yumi = 0, last_acc = 0;
    logic [31:0]   last_data, prev_data, s_a, s_b;
    logic [TW-1:0] last_tag, prev_tag;
    logic          prev_valid = 1'b0, prev_ready = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: sign/zero-extend to 64 bits and take the two's-complement product.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [63:0] ea, eb, p;
        ea = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b1;
        end else begin
            if (flush) sb.delete();
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    s_a       = req_a[i*32 +: 32];
                    s_b       = req_b[i*32 +: 32];
                    e_new.tag = req_tag[i*TW +: TW];
                    e_new.data = ref_result(s_a, s_b, req_op[i*2 +: 2]);
                    e_new.acc = cyc;
                    e_new.lat = (BYP && (s_a == 0 || s_b == 0)) ? 1 : 67;
                    sb.push_back(e_new);
                    grants.push_back(i);
                    last_acc = cyc;
                end
            end
            if (mul_yumi) begin
                yumi_cnt++;
                last_yumi = cyc;
            end
            if (mul_valid_in) mvi_cnt++;
            if (cdb_valid && !prev_valid) begin
                n_rise++;
                if (sb.size() == 0) check("cdb_unexpected", 1, 0);
                else check("latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (cdb_valid && prev_valid && !prev_ready) begin
                check("cdb_data_stable", cdb_data, prev_data);
                check("cdb_tag_stable", cdb_tag, prev_tag);
            end
            if (cdb_valid && cdb_ready) begin
                if (sb.size() == 0) begin
                    check("cdb_unexpected", 1, 0);
                end else begin
                    e_got = sb.pop_front();
                    check("cdb_data", cdb_data, e_got.data);
                    check("cdb_tag", cdb_tag, e_got.tag);
                end
                last_data = cdb_data;
                last_tag  = cdb_tag;
                n_done++;
            end
            prev_valid = cdb_valid;
            prev_ready = cdb_ready;
            prev_data  = cdb_data;
            prev_tag   = cdb_tag;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
    endtask

    task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [TW-1:0] tag);
        int k;
        req_a[idx*32 +: 32]   = a;
        req_b[idx*32 +: 32]   = b;
        req_op[idx*2 +: 2]    = op;
        req_tag[idx*TW +: TW] = tag;
        req_valid[idx]        = 1'b1;
        #1;
        k = 0;
        while (!req_ready[idx] && k < 300) begin
            tick;
            k++;
        end
        check("grant", req_ready[idx], 1);
        tick;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 400) begin
            tick;
            k++;
        end
        check("done", n_done >= target, 1);
    endtask

    task automatic run(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [TW-1:0] tag);
        int t;
        t = n_done + 1;
        issue(idx, a, b, op, tag);
        wait_done(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, k, base, y0, r0, g0, m0;
        reset = 1'b1; flush = 1'b0; cdb_ready = 1'b1;
        req_valid = '1; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        repeat (3) tick;
        check("rst_req_ready", req_ready, 0);
        check("rst_mul_valid_in", mul_valid_in, 0);
        check("rst_mul_yumi", mul_yumi, 0);
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_cdb_tag", cdb_tag, 0);
        check("rst_cdb_data", cdb_data, 0);
        check("rst_multiplier", mul_multiplier, 0);
        check("rst_multiplicand", mul_multiplicand, 0);
        req_valid = '0;
        reset = 1'b0;
        tick;

        run(1, 32'd5, 32'd9, OP_MULHU, 6'd7);
        check("first_grant_req1", grants[0], 1);

        run(0, 32'hFFFFFFF9, 32'd6, OP_MULH, 6'd3);
        check("mulh_neg", last_data, 32'hFFFFFFFF);
        check("mulh_neg_tag", last_tag, 3);
        run(0, 32'hFFFFFFF9, 32'd6, OP_MUL, 6'd4);
        check("mul_neg", last_data, 32'hFFFFFFD6);
        run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULHU, 6'd5);
        check("mulhu_max", last_data, 32'hFFFFFFFE);
        run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL, 6'd6);
        check("mul_max", last_data, 32'h00000001);
        run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULHSU, 6'd8);
        check("mulhsu_max", last_data, 32'hFFFFFFFF);
        run(0, 32'h80000000, 32'h80000000, OP_MULH, 6'd9);
        check("mulh_minint", last_data, 32'h40000000);

        do_reset;
        base = grants.size();
        t = n_done + 4;
        req_a = {32'd5, 32'd3}; req_b = {32'd6, 32'd4};
        req_op = {OP_MUL, OP_MUL}; req_tag = {6'd11, 6'd10};
        req_valid = 2'b11;
        k = 0;
        while (grants.size() < base + 4 && k < 600) begin
            tick;
            k++;
        end
        req_valid = '0;
        check("arb_count", grants.size(), base + 4);
        for (int i = 0; i < 4 && base + i < grants.size(); i++)
            check("arb_order", grants[base + i], i % 2);
        wait_done(t);

        cdb_ready = 1'b0;
        t = n_done + 1;
        issue(0, 32'd100, 32'd200, OP_MUL, 6'd21);
        k = 0;
        while (!cdb_valid && k < 200) begin
            tick;
            k++;
        end
        check("bp_valid", cdb_valid, 1);
        req_a[63:32] = 32'd1; req_b[63:32] = 32'd1; req_op[3:2] = OP_MUL; req_tag[11:6] = 6'd22;
        req_valid[1] = 1'b1;
        #1;
        repeat (5) begin
            check("bp_hold_valid", cdb_valid, 1);
            check("bp_hold_data", cdb_data, 32'd20000);
            check("bp_hold_tag", cdb_tag, 21);
            check("bp_no_grant", req_ready, 0);
            tick;
        end
        req_valid[1] = 1'b0;
        cdb_ready = 1'b1;
        wait_done(t);

        r0 = n_rise;
        y0 = yumi_cnt;
        t = n_done + 1;
        issue(0, 32'd11, 32'd13, OP_MUL, 6'd30);
        repeat (19) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        issue(0, 32'd2, 32'd3, OP_MUL, 6'd31);
        check("flush_yumi_once", yumi_cnt - y0, 1);
        check("drain_then_accept", last_acc - last_yumi, 1);
        wait_done(t);
        check("flush_no_cdb", n_rise - r0, 1);
        check("post_flush_data", last_data, 32'd6);

        g0 = grants.size();
        req_a[31:0] = 32'd7; req_b[31:0] = 32'd7; req_op[1:0] = OP_MUL; req_tag[5:0] = 6'd33;
        req_valid[0] = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_gate", req_ready, 0);
        tick;
        flush = 1'b0;
        req_valid[0] = 1'b0;
        check("flush_no_grant", grants.size(), g0);

        m0 = mvi_cnt;
        run(0, 32'd0, 32'h12345, OP_MUL, 6'd40);
        check("zero_data", last_data, 0);
        check("zero_launch", (mvi_cnt - m0) != 0, BYP ? 0 : 1);

        repeat (3) tick;
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
